// File: rtl/edge_sched_pkg.sv
// Shared definitions for the edge_rate_scheduler slice.
//   state_e     : scheduler FSM states
//   win_timer_w : width of a timer that counts 0 .. cycles-1 (minimum 1 bit)
package edge_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ARM,
    COUNT,
    REPORT
  } state_e;

  function automatic int unsigned win_timer_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/edge_window_counter.sv
// Rising-edge counter for one time-shared input.
//   clk, resetn  : clock, synchronous active-low reset
//   arm_i        : clear count/sat flag, capture the current level as "previous"
//   count_en_i   : count rising edges of s_i this cycle
//   s_i          : selected edge input
//   count_o      : saturating edge count
//   sat_hit_o    : an edge arrived while count_o was already saturated
module edge_window_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             arm_i,
  input  logic             count_en_i,
  input  logic             s_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_hit_o
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             rise;

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    rise   = s_i & ~prev_q;
    if (arm_i) begin
      // capturing the level here means a line already high at mux switch is no edge
      prev_d = s_i;
      cnt_d  = '0;
      sat_d  = 1'b0;
    end else if (count_en_i) begin
      prev_d = s_i;
      if (rise) begin
        if (cnt_q == '1) sat_d = 1'b1;
        else             cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign count_o   = cnt_q;
  assign sat_hit_o = sat_q;

endmodule

// File: rtl/edge_rate_scheduler.sv
// Round-robin rising-edge rate scheduler: one counting datapath shared across
// NUM_CH inputs, one (channel, count) result per WINDOW_CYCLES-clock window.
//   clk, resetn : clock, synchronous active-low reset
//   enable      : run request
//   ch_mask     : channels taking part in the rotation (sampled in SELECT only)
//   s_in        : edge inputs, already synchronous to clk
//   res_valid / res_ready / res_ch / res_count : result stream
//   busy        : high in every state except IDLE
//   res_ovf     : present only when EDGE_SCHED_OVF_EN is defined; an edge hit
//                 a saturated count during the reported window
module edge_rate_scheduler #(
  parameter  int unsigned NUM_CH        = 4,
  parameter  int unsigned WINDOW_CYCLES = 256,
  parameter  int unsigned CNT_W         = 8,
  localparam int unsigned CH_W          = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] s_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [CNT_W-1:0]  res_count,
  output logic              busy
`ifdef EDGE_SCHED_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  import edge_sched_pkg::*;

  localparam int unsigned TW = win_timer_w(WINDOW_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(WINDOW_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CH_W-1:0] last_ch_q, last_ch_d;
  logic [CH_W-1:0] cur_ch_q, cur_ch_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            sel_found;
  logic [CH_W-1:0] sel_ch;
  logic [CH_W:0]   cand;
  logic            sat_hit;

  // First set mask bit strictly after last_ch, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = last_ch_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, last_ch_q} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
      if (!sel_found && ch_mask[cand[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_ch_d = last_ch_q;
    cur_ch_d  = cur_ch_q;
    timer_d   = timer_q;
    unique case (state_q)
      IDLE: begin
        if (enable && (ch_mask != '0)) state_d = SELECT;
      end
      SELECT: begin
        if (sel_found) begin
          cur_ch_d = sel_ch;
          state_d  = ARM;
        end else begin
          state_d  = IDLE;
        end
      end
      ARM: begin
        timer_d = '0;
        state_d = COUNT;
      end
      COUNT: begin
        if (timer_q == TMAX) state_d = REPORT;
        else                 timer_d = timer_q + 1'b1;
      end
      REPORT: begin
        if (res_ready) begin
          last_ch_d = cur_ch_q;
          state_d   = (enable && (ch_mask != '0)) ? SELECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      last_ch_q <= CH_W'(NUM_CH - 1);
      cur_ch_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_ch_q <= last_ch_d;
      cur_ch_q  <= cur_ch_d;
      timer_q   <= timer_d;
    end
  end

  // The counter register is only touched in ARM/COUNT, so it doubles as the
  // held result register throughout REPORT.
  edge_window_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .arm_i      (state_q == ARM),
    .count_en_i (state_q == COUNT),
    .s_i        (s_in[cur_ch_q]),
    .count_o    (res_count),
    .sat_hit_o  (sat_hit)
  );

  assign res_valid = (state_q == REPORT);
  assign res_ch    = cur_ch_q;
  assign busy      = (state_q != IDLE);

`ifdef EDGE_SCHED_OVF_EN
  assign res_ovf = sat_hit;
`else
  logic unused_sat_hit;
  assign unused_sat_hit = sat_hit;
`endif

endmodule
